// File: rtl/vend_sequencer_if.sv
// Vend sequencer bus: host start/price request, money-store read/write
// channel and transaction status, grouped into one interface.
interface vend_sequencer_if;
  logic       start;
  logic [3:0] price;
  logic       rd_en;
  logic       mode;
  logic [3:0] rd_value;
  logic       wr_en;
  logic [3:0] wr_value;
  logic       busy;
  logic       dispense;
  logic       refund;
  logic [3:0] change;
  logic       done;
  logic [7:0] vend_count;

  // Environment side: host request plus money-store read data.
  modport master (
    output start, price, rd_value,
    input  rd_en, mode, wr_en, wr_value, busy, dispense, refund, change,
           done, vend_count
  );

  // Sequencer side.
  modport slave (
    input  start, price, rd_value,
    output rd_en, mode, wr_en, wr_value, busy, dispense, refund, change,
           done, vend_count
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vend sequencer: reads customer and machine money from the store, compares
// against the latched price, then either dispenses (writing the new machine
// money) or refunds. All outputs are registered.
// Optional build macro VEND_SAT_EN: machine money write value saturates at 15
// instead of wrapping modulo 16.
module vend_sequencer (
  input logic            clock,
  input logic            reset_n,
  vend_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_CUST, RD_MACH, CAP_MACH, EVAL, DONE
  } state_t;

  state_t     state;
  logic [3:0] price_q;
  logic [3:0] cust;
  logic [3:0] mach;

  // New machine money after a sale: wraps, or clamps at 15 in the SAT build.
  function automatic logic [3:0] add_money(input logic [3:0] a, input logic [3:0] b);
`ifdef VEND_SAT_EN
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
`else
    return a + b;
`endif
  endfunction

  // Data capture: price on accept, store read data one cycle after each read.
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.start) price_q <= bus.price;
    if (state == RD_MACH)           cust    <= bus.rd_value;
    if (state == CAP_MACH)          mach    <= bus.rd_value;
  end

  // Transaction FSM with registered outputs; outputs are set on entry to the
  // state in which they must be visible.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.rd_en      <= 1'b0;
      bus.mode       <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_value   <= 4'd0;
      bus.busy       <= 1'b0;
      bus.dispense   <= 1'b0;
      bus.refund     <= 1'b0;
      bus.done       <= 1'b0;
      bus.change     <= 4'd0;
      bus.vend_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= RD_CUST;
            bus.busy   <= 1'b1;
            bus.change <= 4'd0;
            bus.rd_en  <= 1'b1;
            bus.mode   <= 1'b1;
          end
        end
        RD_CUST: begin
          state     <= RD_MACH;
          bus.rd_en <= 1'b1;
          bus.mode  <= 1'b0;
        end
        RD_MACH: begin
          state     <= CAP_MACH;
          bus.rd_en <= 1'b0;
          bus.mode  <= 1'b0;
        end
        CAP_MACH: begin
          state <= EVAL;
        end
        EVAL: begin
          state    <= DONE;
          bus.done <= 1'b1;
          if (cust >= price_q) begin
            bus.dispense   <= 1'b1;
            bus.wr_en      <= 1'b1;
            bus.wr_value   <= add_money(mach, price_q);
            bus.change     <= cust - price_q;
            bus.vend_count <= bus.vend_count + 8'd1;
          end else begin
            bus.refund <= 1'b1;
            bus.change <= cust;
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.done     <= 1'b0;
          bus.dispense <= 1'b0;
          bus.refund   <= 1'b0;
          bus.wr_en    <= 1'b0;
          bus.wr_value <= 4'd0;
          bus.busy     <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
